full_adder_checker: RTL and testbench

FULL_ADDER_CHECKER -- requirements
Module: full_adder_checker

---
 rtl/full_adder_checker.sv | 157 +++++++++++++++
 tb/tb_full_adder_checker.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_checker.sv
// ----------------------------------------------------------------------------
// full_adder_checker
//
// Purpose:
//   Exhaustively exercises an external 1-bit full adder. The eight input
//   combinations are applied in order (idx 0..7, {in1, in2, cin} = idx). Each
//   vector is held for SETTLE_CYCLES cycles and then checked on one CHECK
//   cycle. Failing vectors are counted and flagged in a bitmap.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..15)
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      run request, honoured only in IDLE or DONE
//   dut_in1    full adder operand 1        (idx[2])
//   dut_in2    full adder operand 2        (idx[1])
//   dut_cin    full adder carry-in         (idx[0])
//   dut_out    sum returned by the full adder
//   dut_cout   carry-out returned by the full adder
//   busy       high while a run is in progress (SETTLE or CHECK)
//   done       high in DONE, held until the next accepted start or reset
//   pass       high in DONE when no vector failed
//   err_count  number of failing vectors in the current or last run (0..8)
//   fail_vec   bit i set when vector i failed
// ----------------------------------------------------------------------------
module full_adder_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_cin,
    input  logic       dut_out,
    input  logic       dut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    // Settle counter value on the last settle cycle of a vector.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] idx;
    logic [3:0] settle_cnt;
    logic [1:0] expected;
    logic       mismatch;
    logic       accept;
    logic       settle_done;

    // The vector index is the stimulus; no separate input registers exist,
    // so the adder inputs can never disagree with idx.
    assign {dut_in1, dut_in2, dut_cin} = idx;

    // A start is only honoured when no run is in flight.
    assign accept = start && ((state == IDLE) || (state == DONE));

    // Reference full adder: 2-bit {carry, sum} of the three operand bits.
    assign expected    = {1'b0, idx[2]} + {1'b0, idx[1]} + {1'b0, idx[0]};
    assign mismatch    = (expected != {dut_cout, dut_out});
    assign settle_done = (settle_cnt == SETTLE_LAST);

    // State register; reset wins over a simultaneous start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs. pass is only meaningful in DONE and is
    // forced low everywhere else so a stale zero error count never reads as
    // a pass mid-run.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_done) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy       = 1'b1;
                state_next = (idx == 3'd7) ? DONE : SETTLE;
            end
            DONE: begin
                done = 1'b1;
                pass = (err_count == 4'd0);
                if (accept) begin
                    state_next = SETTLE;
                end
            end
        endcase
    end

    // Datapath: vector index, settle counter and result accumulation. idx
    // stays at 7 after the final vector so the inputs do not wrap in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= 3'd0;
            settle_cnt <= 4'd0;
            err_count  <= 4'd0;
            fail_vec   <= 8'h00;
        end else if (accept) begin
            idx        <= 3'd0;
            settle_cnt <= 4'd0;
            err_count  <= 4'd0;
            fail_vec   <= 8'h00;
        end else begin
            unique case (state)
                SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        // Saturate so the 4-bit count can never wrap.
                        if (err_count != 4'd8) begin
                            err_count <= err_count + 4'd1;
                        end
                        fail_vec[idx] <= 1'b1;
                    end
                    if (idx != 3'd7) begin
                        idx        <= idx + 3'd1;
                        settle_cnt <= 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_full_adder_checker.sv
// ----------------------------------------------------------------------------
// tb_full_adder_checker
//
// Purpose:
//   Scoreboard bench for full_adder_checker. u0 (SETTLE_CYCLES=2) drives a
//   full adder model with selectable faults; u1 (SETTLE_CYCLES=1) drives a
//   correct adder. Each accepted start pushes the hand-computed result of
//   that run; a monitor pops and compares on every rising edge of done.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_full_adder_checker;

    typedef struct {
        int         start_edge;
        int         lat;
        logic [3:0] err;
        logic [7:0] fv;
        logic       pass;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start0;
    logic       start1;
    int         fault;
    int         edge_cnt;
    int         checks;
    int         failures;

    logic       in1_0, in2_0, cin_0, out_0, cout_0;
    logic       busy0, done0, pass0;
    logic [3:0] err0;
    logic [7:0] fv0;
    logic [1:0] sum0;

    logic       in1_1, in2_1, cin_1, out_1, cout_1;
    logic       busy1, done1, pass1;
    logic [3:0] err1;
    logic [7:0] fv1;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       mon_e;
    int         busy_cnt[2];
    logic [1:0] done_prev;
    logic [1:0] done_v;
    logic [1:0] busy_v;

    full_adder_checker #(.SETTLE_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .start(start0),
        .dut_in1(in1_0), .dut_in2(in2_0), .dut_cin(cin_0),
        .dut_out(out_0), .dut_cout(cout_0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_vec(fv0)
    );

    full_adder_checker #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .dut_in1(in1_1), .dut_in2(in2_1), .dut_cin(cin_1),
        .dut_out(out_1), .dut_cout(cout_1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    // Full adder under test for u0: fault 0 correct, 1 sum stuck-at-0,
    // 2 carry-out inverted.
    always_comb begin
        sum0   = {1'b0, in1_0} + {1'b0, in2_0} + {1'b0, cin_0};
        out_0  = sum0[0];
        cout_0 = sum0[1];
        if (fault == 1) begin
            out_0 = 1'b0;
        end else if (fault == 2) begin
            cout_0 = ~sum0[1];
        end
    end

    // Correct full adder for u1.
    assign {cout_1, out_1} = {1'b0, in1_1} + {1'b0, in2_1} + {1'b0, cin_1};

    assign done_v = {done1, done0};
    assign busy_v = {busy1, busy0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to time-stamp accepted starts and done rises.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_expect(input int inst, input int start_edge,
                               input logic [3:0] err, input logic [7:0] fv,
                               input int lat);
        exp_t e;
        e.start_edge = start_edge;
        e.lat        = lat;
        e.err        = err;
        e.fv         = fv;
        e.pass       = (err == 4'd0);
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    // Pulse start for one cycle on the chosen instance and record what the
    // completed run must report.
    task automatic apply_stimulus(input int inst, input int f,
                                  input logic [3:0] err, input logic [7:0] fv,
                                  input int lat);
        fault = f;
        @(negedge clk);
        if (inst == 0) start0 = 1'b1;
        else           start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        push_expect(inst, edge_cnt, err, fv, lat);
    endtask

    task automatic wait_done(input int inst, input int budget);
        int n = 0;
        while (((inst == 0) ? done0 : done1) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (((inst == 0) ? done0 : done1) !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL u%0d_timeout: got done=0 after %0d cycles expected done=1",
                     inst, budget);
        end
    endtask

    task automatic check_idle0(input string tag);
        check_output({tag, "_busy"}, busy0, 0);
        check_output({tag, "_done"}, done0, 0);
        check_output({tag, "_pass"}, pass0, 0);
        check_output({tag, "_err"}, err0, 0);
        check_output({tag, "_fv"}, fv0, 0);
        check_output({tag, "_inputs"}, {in1_0, in2_0, cin_0}, 0);
    endtask

    // Monitor: on each rise of done, pop the oldest expectation for that
    // instance and compare latency, busy duration and results.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy_v[i] === 1'b1) begin
                busy_cnt[i]++;
            end else if (done_v[i] !== 1'b1) begin
                busy_cnt[i] = 0;
            end
            if (done_v[i] === 1'b1 && done_prev[i] !== 1'b1) begin
                if (i == 0 && q0.size() > 0) begin
                    mon_e = q0.pop_front();
                    check_output("u0_latency", edge_cnt - mon_e.start_edge, mon_e.lat);
                    check_output("u0_busy_cycles", busy_cnt[0], mon_e.lat);
                    check_output("u0_pass", pass0, mon_e.pass);
                    check_output("u0_err_count", err0, mon_e.err);
                    check_output("u0_fail_vec", fv0, mon_e.fv);
                end else if (i == 1 && q1.size() > 0) begin
                    mon_e = q1.pop_front();
                    check_output("u1_latency", edge_cnt - mon_e.start_edge, mon_e.lat);
                    check_output("u1_busy_cycles", busy_cnt[1], mon_e.lat);
                    check_output("u1_pass", pass1, mon_e.pass);
                    check_output("u1_err_count", err1, mon_e.err);
                    check_output("u1_fail_vec", fv1, mon_e.fv);
                end else begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL u%0d_unexpected_done: got done=1 expected no run pending", i);
                end
                busy_cnt[i] = 0;
            end
            done_prev[i] = done_v[i];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        edge_cnt    = 0;
        checks      = 0;
        failures    = 0;
        busy_cnt[0] = 0;
        busy_cnt[1] = 0;
        done_prev   = 2'b00;
        rst         = 1'b1;
        start0      = 1'b0;
        start1      = 1'b0;
        fault       = 0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_idle0("reset");
        check_output("reset_u1_busy", busy1, 0);
        check_output("reset_u1_done", done1, 0);
        rst = 1'b0;
        @(negedge clk);

        // Correct adder: 24 busy cycles, then pass; done holds afterwards.
        apply_stimulus(0, 0, 4'd0, 8'h00, 24);
        wait_done(0, 200);
        repeat (5) @(negedge clk);
        check_output("done_held", done0, 1);
        check_output("pass_held", pass0, 1);

        // Sum stuck-at-0: vectors 1, 2, 4, 7 have sum 1.
        apply_stimulus(0, 1, 4'd4, 8'b1001_0110, 24);
        wait_done(0, 200);

        // Carry-out inverted: every vector fails.
        apply_stimulus(0, 2, 4'd8, 8'hFF, 24);
        wait_done(0, 200);

        // start held high: no restart until DONE, then restart at once.
        fault = 2;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        push_expect(0, edge_cnt, 4'd8, 8'hFF, 24);
        wait_done(0, 200);
        fault = 0;
        push_expect(0, edge_cnt + 1, 4'd0, 8'h00, 24);
        @(negedge clk);
        check_output("restart_done", done0, 0);
        check_output("restart_busy", busy0, 1);
        check_output("restart_err", err0, 0);
        check_output("restart_fv", fv0, 0);
        start0 = 1'b0;
        wait_done(0, 200);

        // Reset on the 10th cycle of a faulty run, together with start.
        fault = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        check_output("abort_err_before_rst", err0, 2);
        rst    = 1'b1;
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle0("abort");
        rst    = 1'b0;
        start0 = 1'b0;
        apply_stimulus(0, 0, 4'd0, 8'h00, 24);
        wait_done(0, 200);

        // SETTLE_CYCLES=1: each vector held two cycles, done after 16 edges.
        apply_stimulus(1, 0, 4'd0, 8'h00, 16);
        check_output("u1_step0", {in1_1, in2_1, cin_1}, 0);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            check_output($sformatf("u1_step%0d", k), {in1_1, in2_1, cin_1}, k / 2);
        end
        wait_done(1, 100);
        @(negedge clk);
        check_output("u1_inputs_done", {in1_1, in2_1, cin_1}, 7);

        repeat (3) @(negedge clk);
        check_output("q0_drained", q0.size(), 0);
        check_output("q1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
